tube_tdc_array: RTL and testbench
=================================

Name: tube_tdc_array

Overview:
- Multi-channel drift-time counter for the tube front end; a parametrised successor to the single-tube counter.
- For each of NCH tubes it measures the clock cycles from gate open to the first tube hit, including a configurable look-back window, and saturates on no-hit.
- When the gate closes it reads all channels out, in channel order, over a valid/ready stream into the event FIFO.

Parameters:
- NCH, 8, number of tube channels.
- CH_W, 3, channel index width; must satisfy 2^CH_W >= NCH.
- CNT_W, 8, counter width; saturates at 2^CNT_W-1.
- LOOKBACK, 8, delay in clk cycles of each tube input before hit detection; must be >= 1.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-high reset.
- tube_in  in  NCH  raw tube discriminator levels, synchronous to clk.
- gate_en  in  1  measurement window, level, synchronous.
- out_data  out  CH_W+1+CNT_W  readout word {ch_idx, hit, cnt}.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts word.
- busy  out  1  high when state is not IDLE.
- missed_gate  out  1  one-cycle pulse: gate_en rising edge seen during READOUT.

Behaviour:
- Reset (clr=1, async): state IDLE; all delay lines, counters, hit flags, gate_prev and read index are 0; out_valid=0, out_data=0, busy=0, missed_gate=0.
- Per-channel delay line, LOOKBACK deep, runs free in every state. dly[ch] is tube_in[ch] as sampled LOOKBACK clocks earlier.
- IDLE: when gate_en=1, clear all cnt and hit, then go to MEASURE. No counting happens in this cycle.
- MEASURE, gate_en=1, for each channel with hit=0:
  - if hit condition is true: set hit=1; cnt freezes at its current value (no increment this cycle).
  - else if cnt < 2^CNT_W-1: cnt+1.
  - else: cnt holds (saturated).
- MEASURE, channels with hit=1 hold; only the first hit per window is recorded.
- Result: a level that first appears at tube_in during MEASURE cycle k (cycle 0 = first MEASURE cycle) reports cnt = k+LOOKBACK, if that is <= 2^CNT_W-1. Hits up to LOOKBACK cycles before gate open report smaller counts.
- MEASURE, gate_en=0: go to READOUT with idx=0. Counters freeze.
- READOUT:
  - out_valid=1, out_data={idx, hit[idx], cnt[idx]}.
  - Data stays stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready: idx+1. After idx=NCH-1 is accepted, out_valid=0 the next cycle and state returns to IDLE.
  - A new word is presented the cycle after each accept. Maximum throughput is one word per cycle.
- gate_en in READOUT is ignored for measurement. A rising edge (gate_en=1, gate_prev=0) asserts missed_gate for exactly one cycle.
- If gate_en is still high on return to IDLE, a new window opens immediately.
- clr asserted mid-MEASURE or mid-READOUT aborts immediately: full reset values apply and the partial readout is discarded.
- Simultaneous hits on several channels in the same cycle are each recorded independently.

Optional Feature:
- Macro TUBE_TDC_EDGE_EN.
- Defined: hit condition = rising edge of dly[ch] (dly=1 and its previous value 0, previous register reset to 0). A tube already high before the window and held high never registers.
- Undefined: hit condition = dly[ch]==1 (level). A tube held high registers a hit with cnt=0 in the first MEASURE cycle.

Test Plan:
- NCH=4, CNT_W=8, LOOKBACK=8. Gate high 100 cycles; tube_in[1] goes and stays high from MEASURE cycle 12 -> words in order ch0..ch3. ch1 = {1, hit=1, cnt=20}; other channels hit=0, cnt=100.
- Gate high 300 cycles, no tube activity -> all 4 words hit=0, cnt=255 (saturated); busy drops the cycle after the 4th accept.
- Readout with out_ready low for 5 cycles on each word -> out_valid held, out_data stable, order 0,1,2,3, then IDLE.
- gate_en pulses low-to-high during READOUT -> missed_gate high for exactly 1 cycle; no counter changes; remaining words unchanged.
- clr asserted on MEASURE cycle 40 -> next cycle: state IDLE, busy=0, out_valid=0, all counters 0. A subsequent window measures normally.
- tube_in[2] held high from 20 cycles before gate, gate 50 cycles:
  - without TUBE_TDC_EDGE_EN -> ch2 hit=1, cnt=0.
  - with TUBE_TDC_EDGE_EN -> ch2 hit=0, cnt=50.

Source files
------------

// File: rtl/tube_tdc_array.sv
// Multi-channel drift-time counter: per tube, clk cycles from gate open to first hit (with look-back), saturating.
// Latency: tube_in reaches hit detection LOOKBACK cycles later; readout word presented the cycle after gate closes.
// Backpressure: out_data/out_valid held stable while out_ready=0; one word per cycle at full throughput.
//
// Ports:
//   clk, clr         system clock, asynchronous active-high reset
//   tube_in[NCH]     raw tube discriminator levels (synchronous to clk)
//   gate_en          measurement window level
//   out_data         readout word {ch_idx, hit, cnt}, 0 when out_valid=0
//   out_valid/ready  readout stream handshake
//   busy             high whenever the block is not IDLE
//   missed_gate      one-cycle pulse when gate_en rises during READOUT
//
// Build option: define TUBE_TDC_EDGE_EN to register hits on the rising edge of the
// delayed tube level instead of on the level itself.
module tube_tdc_array #(
    parameter int NCH      = 8,
    parameter int CH_W     = 3,
    parameter int CNT_W    = 8,
    parameter int LOOKBACK = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NCH-1:0]        tube_in,
    input  logic                  gate_en,
    output logic [CH_W+CNT_W:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  missed_gate
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEAS = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CH_W-1:0]  LAST_IDX = CH_W'(NCH - 1);

    logic [1:0]       r_state;
    logic [NCH-1:0]   r_dly [LOOKBACK];     // r_dly[0] is the most recent sample
    logic [CNT_W-1:0] r_cnt [NCH];
    logic [NCH-1:0]   r_hit;
    logic [CH_W-1:0]  r_idx;
    logic             r_gate_prev;
    logic             r_missed;

    logic [NCH-1:0]   w_dly;
    logic [NCH-1:0]   w_hit_cond;

    assign w_dly = r_dly[LOOKBACK-1];

    // Delay line runs in every state so the look-back window is already
    // populated when the gate opens.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < LOOKBACK; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= tube_in;
            for (int i = 1; i < LOOKBACK; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

`ifdef TUBE_TDC_EDGE_EN
    logic [NCH-1:0] r_dly_prev;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_dly_prev <= '0;
        end else begin
            r_dly_prev <= w_dly;
        end
    end

    // A tube that was already high before the window never produces an edge.
    assign w_hit_cond = w_dly & ~r_dly_prev;
`else
    assign w_hit_cond = w_dly;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_hit   <= '0;
            r_idx   <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                r_cnt[ch] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (gate_en) begin
                        r_hit <= '0;
                        for (int ch = 0; ch < NCH; ch++) begin
                            r_cnt[ch] <= '0;
                        end
                        r_state <= S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (gate_en) begin
                        for (int ch = 0; ch < NCH; ch++) begin
                            // Only the first hit in a window is kept; the count
                            // freezes on the hit cycle itself.
                            if (!r_hit[ch]) begin
                                if (w_hit_cond[ch]) begin
                                    r_hit[ch] <= 1'b1;
                                end else if (r_cnt[ch] != CNT_MAX) begin
                                    r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
                                end
                            end
                        end
                    end else begin
                        r_idx   <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + CH_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Gate edge tracking is independent of state; only READOUT reports it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_gate_prev <= 1'b0;
            r_missed    <= 1'b0;
        end else begin
            r_gate_prev <= gate_en;
            r_missed    <= (r_state == S_READ) && gate_en && !r_gate_prev;
        end
    end

    assign out_valid   = (r_state == S_READ);
    assign out_data    = out_valid ? {r_idx, r_hit[r_idx], r_cnt[r_idx]} : '0;
    assign busy        = (r_state != S_IDLE);
    assign missed_gate = r_missed;

endmodule

// File: tb/tb_tube_tdc_array.sv
// Bench for tube_tdc_array (NCH=4, CNT_W=8, LOOKBACK=8): directed windows,
// expected readout words queued at issue time and checked by a monitor.
module tb_tube_tdc_array;

    localparam int NCH      = 4;
    localparam int CH_W     = 2;
    localparam int CNT_W    = 8;
    localparam int LOOKBACK = 8;
    localparam int DW       = CH_W + 1 + CNT_W;

    logic           clk = 1'b0;
    logic           clr;
    logic [NCH-1:0] tube_in;
    logic           gate_en;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           missed_gate;

    int checks   = 0;
    int errors   = 0;
    int n_missed = 0;
    bit chk_last = 1'b0;

    logic [DW-1:0] exp_q [$];

    tube_tdc_array #(
        .NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W), .LOOKBACK(LOOKBACK)
    ) dut (
        .clk(clk), .clr(clr), .tube_in(tube_in), .gate_en(gate_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .missed_gate(missed_gate)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int ch, input bit hit, input int cnt);
        logic [CH_W-1:0]  c;
        logic [CNT_W-1:0] n;
        c = ch[CH_W-1:0];
        n = cnt[CNT_W-1:0];
        return {c, hit, n};
    endfunction

    task automatic push4(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        exp_q.push_back(w3);
    endtask

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: compares every presented word against the head of the queue,
    // pops on accept, and checks busy drops right after the last channel.
    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (chk_last) begin
            chk_last = 1'b0;
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_last: busy=%b out_valid=%b expected 0 0", busy, out_valid);
            end
        end
        if (missed_gate === 1'b1) n_missed++;
        if (clr === 1'b0 && out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %0h with nothing expected", out_data);
            end else begin
                if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL word: got %0h expected %0h", out_data, exp_q[0]);
                end
                if (out_ready === 1'b1) begin
                    w = exp_q.pop_front();
                    if (w[DW-1 -: CH_W] == CH_W'(NCH-1)) chk_last = 1'b1;
                end
            end
        end
    end

    // Gate high for n MEASURE cycles; tubes in mask rise during MEASURE cycle k.
    task automatic run_window(input int n, input logic [NCH-1:0] mask, input int k);
        gate_en = 1'b1;
        for (int c = 0; c <= n; c++) begin
            @(posedge clk); #1;
            if (c == k) tube_in = tube_in | mask;
        end
        gate_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b pending=%0d expected idle", name, busy, exp_q.size());
        end
        tube_in = '0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic drain_stall(input int nstall);
        int t;
        out_ready = 1'b0;
        for (int w = 0; w < NCH; w++) begin
            t = 0;
            while (out_valid !== 1'b1 && t < 500) begin
                @(posedge clk); #1;
                t++;
            end
            check1("stall_wait_valid", {31'd0, out_valid}, 32'd1);
            repeat (nstall) begin
                @(posedge clk); #1;
                check1("stall_valid_held", {31'd0, out_valid}, 32'd1);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0;
        clr       = 1'b1;
        tube_in   = '0;
        gate_en   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_busy", {31'd0, busy}, 32'd0);
        check1("rst_valid", {31'd0, out_valid}, 32'd0);
        check1("rst_data", {21'd0, out_data}, 32'd0);
        check1("rst_missed", {31'd0, missed_gate}, 32'd0);
        clr = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Single late hit on ch1.
        push4(mk(0, 0, 100), mk(1, 1, 20), mk(2, 0, 100), mk(3, 0, 100));
        run_window(100, 4'b0010, 12);
        wait_idle("t1");

        // No activity: every channel saturates.
        push4(mk(0, 0, 255), mk(1, 0, 255), mk(2, 0, 255), mk(3, 0, 255));
        run_window(300, 4'b0000, -1);
        wait_idle("t2");

        // Simultaneous hits, readout stalled 5 cycles per word.
        push4(mk(0, 1, 13), mk(1, 0, 20), mk(2, 1, 13), mk(3, 0, 20));
        out_ready = 1'b0;
        run_window(20, 4'b0101, 5);
        drain_stall(5);
        wait_idle("t3");

        // Gate pulse during stalled readout.
        push4(mk(0, 0, 30), mk(1, 0, 30), mk(2, 0, 30), mk(3, 0, 30));
        out_ready = 1'b0;
        run_window(30, 4'b0000, -1);
        m0 = n_missed;
        repeat (3) @(posedge clk);
        #1 gate_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 gate_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check1("missed_gate_cycles", n_missed - m0, 32'd1);
        drain_stall(1);
        wait_idle("t4");

        // Reset during MEASURE cycle 40 aborts the window.
        gate_en = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk); #1;
        end
        check1("pre_clr_busy", {31'd0, busy}, 32'd1);
        clr     = 1'b1;
        gate_en = 1'b0;
        @(negedge clk);
        check1("clr_busy", {31'd0, busy}, 32'd0);
        check1("clr_valid", {31'd0, out_valid}, 32'd0);
        check1("clr_data", {21'd0, out_data}, 32'd0);
        check1("clr_hit", {28'd0, dut.r_hit}, 32'd0);
        for (int ch = 0; ch < NCH; ch++) begin
            check1("clr_cnt", {24'd0, dut.r_cnt[ch]}, 32'd0);
        end
        @(posedge clk);
        #1 clr = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Normal window after abort.
        push4(mk(0, 0, 30), mk(1, 0, 30), mk(2, 0, 30), mk(3, 1, 13));
        run_window(30, 4'b1000, 5);
        wait_idle("t6");

        // ch2 already high 20 cycles before the gate opens.
`ifdef TUBE_TDC_EDGE_EN
        push4(mk(0, 0, 50), mk(1, 0, 50), mk(2, 0, 50), mk(3, 0, 50));
`else
        push4(mk(0, 0, 50), mk(1, 0, 50), mk(2, 1, 0), mk(3, 0, 50));
`endif
        tube_in = 4'b0100;
        repeat (20) @(posedge clk);
        #1;
        run_window(50, 4'b0000, -1);
        wait_idle("t7");

        check1("missed_gate_total", n_missed, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
